// File: rtl/fetch_queue_pkg.sv
// Shared CPU front-end definitions: queue entry layout and the default bubble instruction.
package fetch_queue_pkg;

  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013;  // addi x0, x0, 0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Fetch queue storage: DEPTH entries of {pc, inst}, one synchronous write, one async read.
module fq_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  fq_entry_t                wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output fq_entry_t                rdata
);

  fq_entry_t mem [DEPTH];

  // No reset: validity is tracked entirely by the pointers in the controller.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-gated memory requests, registered push of the
// returning word, and a head entry presented to decode with valid/ready.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fetch_pc,
  input  logic [31:0]              im_data,
  output logic                     im_req,
  output logic                     pc_hold,
  input  logic                     flush,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [31:0]              id_pc,
  output logic [31:0]              id_inst,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          inflight;
  logic          kill;
  logic [31:0]   req_pc;

  logic          credit;
  logic          push;
  logic          pop;
  fq_entry_t     wr_entry;
  fq_entry_t     head_entry;

  // An outstanding request already owns a slot, so it counts against capacity.
  assign credit   = (count + CW'(inflight)) < FULL;
  assign im_req   = credit & ~flush & ~rst;
  assign pc_hold  = ~im_req;

  assign push     = inflight & ~kill & ~flush & ~rst;
  assign id_valid = (count != '0) & ~rst;
  assign pop      = id_valid & id_ready;

  assign id_pc    = id_valid ? head_entry.pc   : '0;
  assign id_inst  = id_valid ? head_entry.inst : NOP_INST;
  assign q_count  = count;

  assign wr_entry = '{pc: req_pc, inst: im_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
      req_pc   <= '0;
    end else begin
      if (im_req) req_pc <= fetch_pc;
      inflight <= im_req;
      kill     <= flush;
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + AW'(1);
        if (pop)  head <= head + AW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  fq_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (head_entry)
  );

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4; queue entries, power of two, 2..16.
REQ-002 SHALL have parameter NOP_INST, default 32'h0000_0013; value driven on id_inst when id_valid=0.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port fetch_pc  input  32  current PC-stage register value (byte address).
REQ-006 SHALL have port im_data  input  32  instruction memory read data, valid exactly one cycle after im_req.
REQ-007 SHALL have port im_req  output  1  instruction memory read enable for address fetch_pc[15:2].
REQ-008 SHALL have port pc_hold  output  1  to PC stage; 1 forces PC select "hold".
REQ-009 SHALL have port flush  input  1  redirect (taken branch/jump); discards all fetched-but-unissued work.
REQ-010 SHALL have port id_valid  output  1  head entry valid toward decode.
REQ-011 SHALL have port id_ready  input  1  decode accepts head entry.
REQ-012 SHALL have port id_pc  output  32  PC of head entry.
REQ-013 SHALL have port id_inst  output  32  instruction of head entry.
REQ-014 SHALL have port q_count  output  $clog2(DEPTH)+1  occupied entries.

Function
REQ-015 SHALL compute credit = (q_count + inflight) < DEPTH, where inflight is the 1-bit outstanding-request flag.
REQ-016 SHALL drive im_req = credit & ~flush & ~rst; pc_hold = ~im_req (combinational).
REQ-017 SHALL, on im_req, latch fetch_pc into req_pc and set inflight=1 next cycle; otherwise clear inflight.
REQ-018 SHALL, in the cycle inflight=1 and kill=0, push {req_pc, im_data} at tail; pointers wrap modulo DEPTH.
REQ-019 SHALL pop head when id_valid & id_ready; push and pop in the same cycle keep q_count unchanged.
REQ-020 SHALL drive id_valid = (q_count != 0); id_pc/id_inst from head entry; id_inst = NOP_INST, id_pc = 0 when empty.
REQ-021 SHALL, on flush: next cycle q_count=0, head=tail=0, id_valid=0; any response arriving that cycle is dropped (kill=1 for one cycle).
REQ-022 SHALL give flush priority over simultaneous push and pop; a pop in the flush cycle still counts as accepted by decode.
REQ-023 SHALL keep outputs stable while id_valid=1 and id_ready=0.
REQ-024 SHALL never push when full; credit accounting guarantees this (assertion in bench).
REQ-025 SHALL have fetch-to-decode latency of 2 cycles: PC presented cycle N, id_valid earliest N+2 (N+1 response, registered push).

Reset
REQ-026 SHALL, while rst=1 at a clock edge, set head=tail=0, q_count=0, inflight=0, kill=0, req_pc=0.
REQ-027 SHALL drive im_req=0, pc_hold=1, id_valid=0, id_inst=NOP_INST, id_pc=0 during reset.
REQ-028 SHALL, when reset asserts mid-operation, discard all entries and the in-flight response with no partial push.

Structure
REQ-029 SHALL take NOP_INST default and the {pc,inst} entry struct type from the shared cpu package.
REQ-030 SHALL implement storage as one sub-module fq_ram (DEPTH x 64-bit, 1 write, 1 async read port); control stays in fetch_queue.

Verification
REQ-031 SHALL test reset: rst=1 two cycles with fetch_pc=32'h40 -> im_req=0, pc_hold=1, id_valid=0, id_inst=32'h13; first im_req cycle after rst falls.
REQ-032 SHALL test streaming: id_ready=1, PC stepping 0,4,8 -> id_pc=0,4,8 on cycles 2,3,4 with matching im_data; q_count stays <=1.
REQ-033 SHALL test fill: id_ready=0, DEPTH=4 -> im_req for exactly 4 requests, then pc_hold=1 and q_count=4; releasing id_ready for one cycle -> q_count=3, one new im_req.
REQ-034 SHALL test flush with in-flight: flush in cycle after im_req for PC 32'h10, q_count=2 -> next cycle q_count=0, id_valid=0; PC 32'h10 never appears on id_pc.
REQ-035 SHALL test simultaneous push/pop at full, plus flush and pop in the same cycle -> q_count constant in the former, 0 in the latter.
REQ-036 SHALL test mid-stream reset with q_count=3 -> next cycle q_count=0, id_valid=0, no stale entry issued after release.
